tx_dac_sequencer: RTL and testbench



---
 rtl/tx_dac_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_tx_dac_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_dac_sequencer.sv
// TX DAC sequencer: paces sample requests from the upstream TX FIFO reader,
// double-buffers one sample set per frame, interleaves I/Q words onto a 14-bit
// DAC bus and mutes the output while the FIFO underruns.
module tx_dac_sequencer #(
   parameter int UNMUTE_STROBES = 4
) (
   input  logic        txclk,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  interp_rate,
   input  logic [3:0]  channels,
   input  logic [15:0] tx_i_0,
   input  logic [15:0] tx_q_0,
   input  logic [15:0] tx_i_1,
   input  logic [15:0] tx_q_1,
   input  logic        tx_empty,
   output logic        txstrobe,
   output logic [13:0] dac_data,
   output logic        dac_frame,
   output logic        muted,
   output logic [15:0] underrun_count
);

   localparam int GW = $clog2(UNMUTE_STROBES + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_MUTE = 2'd2
   } state_t;

   state_t           state_r, state_next_s;
   logic [7:0]       strobe_cnt_r, cnt_next_s, reload_s;
   logic             strobe_r;
   logic [1:0]       slot_r;
   logic [GW-1:0]    good_cnt_r, good_next_s;
   logic [3:0][15:0] pend_r, act_r, capt_s;
   logic [13:0]      dac_data_r;
   logic             dac_frame_r;
   logic             muted_r;
   logic [15:0]      underrun_r, underrun_next_s;

   // Round 16-bit two's complement to 14 bits; only the positive edge can overflow.
   function automatic logic [13:0] to_dac14(input logic [15:0] x);
      logic [15:0] sum;
      sum = x + 16'd2;
      if (!x[15] && sum[15]) begin
         to_dac14 = 14'h1FFF;
      end else begin
         to_dac14 = sum[15:2];
      end
   endfunction

   // Strobe period never drops below the number of words per sample set.
   always_comb begin
      if (interp_rate >= {4'd0, channels}) begin
         reload_s = interp_rate;
      end else begin
         reload_s = {4'd0, channels};
      end
   end

   // Next state, strobe countdown, good-strobe run length and underrun tally.
   always_comb begin
      state_next_s    = state_r;
      cnt_next_s      = strobe_cnt_r;
      good_next_s     = good_cnt_r;
      underrun_next_s = underrun_r;
      case (state_r)
         ST_IDLE: begin
            state_next_s = ST_RUN;
            cnt_next_s   = reload_s;
            good_next_s  = {GW{1'b0}};
         end
         ST_RUN: begin
            if (strobe_r) begin
               cnt_next_s = reload_s;
            end else begin
               cnt_next_s = strobe_cnt_r - 8'd1;
            end
            if (strobe_r && tx_empty) begin
               state_next_s = ST_MUTE;
               good_next_s  = {GW{1'b0}};
               if (underrun_r != 16'hFFFF) begin
                  underrun_next_s = underrun_r + 16'd1;
               end else begin
                  underrun_next_s = underrun_r;
               end
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_MUTE: begin
            if (strobe_r) begin
               cnt_next_s = reload_s;
            end else begin
               cnt_next_s = strobe_cnt_r - 8'd1;
            end
            if (good_cnt_r == GW'(UNMUTE_STROBES)) begin
               state_next_s = ST_RUN;
               good_next_s  = {GW{1'b0}};
            end else if (strobe_r && tx_empty) begin
               good_next_s = {GW{1'b0}};
            end else if (strobe_r) begin
               good_next_s = good_cnt_r + GW'(1);
            end else begin
               good_next_s = good_cnt_r;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            cnt_next_s   = 8'd0;
            good_next_s  = {GW{1'b0}};
         end
      endcase
   end

   // Sample set latched on a strobe; zeros while starved or muted, channel B zero when mono.
   always_comb begin
      capt_s = pend_r;
      if (strobe_r) begin
         if (tx_empty || (state_r == ST_MUTE)) begin
            capt_s = 64'd0;
         end else if (channels == 4'd2) begin
            capt_s = {16'd0, 16'd0, tx_q_0, tx_i_0};
         end else begin
            capt_s = {tx_q_1, tx_i_1, tx_q_0, tx_i_0};
         end
      end else begin
         capt_s = pend_r;
      end
   end

   // All sequencer state; enable low parks in IDLE but keeps the underrun tally.
   always_ff @(posedge txclk) begin
      if (reset || !enable) begin
         state_r      <= ST_IDLE;
         strobe_cnt_r <= 8'd0;
         strobe_r     <= 1'b0;
         slot_r       <= 2'd0;
         good_cnt_r   <= {GW{1'b0}};
         pend_r       <= 64'd0;
         act_r        <= 64'd0;
         dac_data_r   <= 14'd0;
         dac_frame_r  <= 1'b0;
         muted_r      <= 1'b0;
         if (reset) begin
            underrun_r <= 16'd0;
         end else begin
            underrun_r <= underrun_r;
         end
      end else begin
         state_r      <= state_next_s;
         strobe_cnt_r <= cnt_next_s;
         strobe_r     <= (cnt_next_s == 8'd0);
         good_cnt_r   <= good_next_s;
         underrun_r   <= underrun_next_s;
         muted_r      <= (state_next_s == ST_MUTE);
         pend_r       <= capt_s;
         if (state_r == ST_IDLE) begin
            slot_r      <= 2'd0;
            dac_data_r  <= 14'd0;
            dac_frame_r <= 1'b0;
         end else begin
            slot_r      <= slot_r + 2'd1;
            dac_data_r  <= to_dac14(act_r[slot_r]);
            dac_frame_r <= (slot_r == 2'd0);
            // A whole sample set swaps in only at the frame boundary.
            if (slot_r == 2'd3) begin
               act_r <= pend_r;
            end
         end
      end
   end

   assign txstrobe       = strobe_r;
   assign dac_data       = dac_data_r;
   assign dac_frame      = dac_frame_r;
   assign muted          = muted_r;
   assign underrun_count = underrun_r;

endmodule

// File: tb/tb_tx_dac_sequencer.sv
// Directed bench for tx_dac_sequencer: per-cycle log of outputs, frame scoreboard.
module tb_tx_dac_sequencer;

   logic        txclk = 1'b0;
   logic        reset, enable, tx_empty;
   logic [7:0]  interp_rate;
   logic [3:0]  channels;
   logic [15:0] tx_i_0, tx_q_0, tx_i_1, tx_q_1;
   logic        txstrobe, dac_frame, muted;
   logic [13:0] dac_data;
   logic [15:0] underrun_count;

   tx_dac_sequencer #(.UNMUTE_STROBES(4)) dut (
      .txclk(txclk), .reset(reset), .enable(enable),
      .interp_rate(interp_rate), .channels(channels),
      .tx_i_0(tx_i_0), .tx_q_0(tx_q_0), .tx_i_1(tx_i_1), .tx_q_1(tx_q_1),
      .tx_empty(tx_empty), .txstrobe(txstrobe), .dac_data(dac_data),
      .dac_frame(dac_frame), .muted(muted), .underrun_count(underrun_count)
   );

   always #5 txclk = ~txclk;

   localparam int LOGN = 1024;
   int passed = 0;
   int failed = 0;
   int total  = 0;
   int cyc    = 0;
   logic        log_strobe [LOGN];
   logic        log_frame  [LOGN];
   logic        log_muted  [LOGN];
   logic [13:0] log_data   [LOGN];

   typedef struct {
      int at;
      int id;
      logic [3:0][13:0] w;
   } exp_t;
   exp_t sb_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge txclk);
      cyc++;
      if (cyc >= LOGN) begin
         $display("FAIL log_overflow: observed cycle %0d required below %0d", cyc, LOGN);
         $fatal(1);
      end
      log_strobe[cyc] = txstrobe;
      log_frame[cyc]  = dac_frame;
      log_muted[cyc]  = muted;
      log_data[cyc]   = dac_data;
   endtask

   // Spec-level model: round half up by +2, arithmetic shift, clip at +8191.
   function automatic logic [13:0] model14(input logic [15:0] x);
      int v;
      v = int'($signed(x));
      v = (v + 2) >>> 2;
      if (v > 8191) v = 8191;
      return v[13:0];
   endfunction

   task automatic sb_push(input int at, input int id, input logic [13:0] a0, input logic [13:0] a1,
                          input logic [13:0] a2, input logic [13:0] a3);
      exp_t e;
      e.at = at; e.id = id;
      e.w[0] = a0; e.w[1] = a1; e.w[2] = a2; e.w[3] = a3;
      sb_q.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      while (sb_q.size() > 0 && (sb_q[0].at + 3 <= cyc)) begin
         e = sb_q.pop_front();
         chk($sformatf("frame%0d_start", e.id), 32'(log_frame[e.at]), 32'd1);
         for (int i = 0; i < 4; i++)
            chk($sformatf("frame%0d_slot%0d", e.id, i), 32'(log_data[e.at + i]), 32'(e.w[i]));
      end
   endtask

   task automatic wait_strobe(output int s);
      int n;
      n = 0;
      step();
      while (!log_strobe[cyc] && n < 64) begin
         step();
         n++;
      end
      chk("strobe_wait", 32'(log_strobe[cyc]), 32'd1);
      s = cyc;
   endtask

   // Present tx_empty during the next strobe cycle, then drop it again.
   task automatic do_strobe(input logic empty, output int s);
      wait_strobe(s);
      tx_empty = empty;
      step();
      tx_empty = 1'b0;
   endtask

   initial begin
      int base, s, s6, mcount, fl, sid;
      int st[$];
      int fr[$];
      logic [13:0] d1 [4];
      logic pat [8];

      reset = 1'b1; enable = 1'b0; tx_empty = 1'b0;
      interp_rate = 8'd7; channels = 4'd4;
      tx_i_0 = 16'd0; tx_q_0 = 16'd0; tx_i_1 = 16'd0; tx_q_1 = 16'd0;
      sid = 0;
      repeat (3) step();
      chk("rst_txstrobe", 32'(txstrobe), 32'd0);
      chk("rst_dac_data", 32'(dac_data), 32'd0);
      chk("rst_dac_frame", 32'(dac_frame), 32'd0);
      chk("rst_muted", 32'(muted), 32'd0);
      chk("rst_underrun", 32'(underrun_count), 32'd0);

      // Strobe/frame timing and the width-conversion corners.
      tx_i_0 = 16'h7FFF; tx_q_0 = 16'h8000; tx_i_1 = 16'h0006; tx_q_1 = 16'hFFFE;
      reset = 1'b0; enable = 1'b1; base = cyc;
      sb_push(base + 10, sid++, 14'd0, 14'd0, 14'd0, 14'd0);
      sb_push(base + 14, sid++, 14'h1FFF, 14'h2000, 14'h0002, 14'h0000);
      repeat (40) step();
      for (int i = base + 1; i <= cyc; i++) begin
         if (log_strobe[i]) st.push_back(i);
         if (log_frame[i]) fr.push_back(i);
      end
      chk("strobe_count", 32'(st.size()), 32'd5);
      if (st.size() >= 3) begin
         chk("first_strobe", 32'(st[0] - base), 32'd8);
         chk("strobe_gap1", 32'(st[1] - st[0]), 32'd8);
         chk("strobe_gap2", 32'(st[2] - st[1]), 32'd8);
      end
      chk("frame_count", 32'(fr.size()), 32'd10);
      if (fr.size() >= 3) begin
         chk("first_frame", 32'(fr[0] - base), 32'd2);
         chk("frame_gap", 32'(fr[2] - fr[1]), 32'd4);
      end
      sb_check();

      // Mono operation with the fastest strobe.
      channels = 4'd2; interp_rate = 8'd0;
      tx_i_0 = 16'h0100; tx_q_0 = 16'hFF00; tx_i_1 = 16'h1234; tx_q_1 = 16'h5678;
      base = cyc;
      repeat (40) step();
      st.delete();
      fl = 0;
      for (int i = base + 1; i <= cyc; i++) begin
         if (log_strobe[i]) st.push_back(i);
         if (log_frame[i] && (i + 3 <= cyc)) fl = i;
      end
      if (st.size() >= 2) chk("mono_period", 32'(st[st.size() - 1] - st[st.size() - 2]), 32'd3);
      else chk("mono_strobes", 32'(st.size()), 32'd2);
      chk("mono_frame_found", 32'(fl > base + 20), 32'd1);
      chk("mono_slot0", 32'(log_data[fl]), 32'h0040);
      chk("mono_slot1", 32'(log_data[fl + 1]), 32'h3FC0);
      chk("mono_slot2", 32'(log_data[fl + 2]), 32'h0000);
      chk("mono_slot3", 32'(log_data[fl + 3]), 32'h0000);

      // Underrun then four good strobes; realign first with an enable pulse.
      interp_rate = 8'd7; channels = 4'd4;
      tx_i_0 = 16'h1235; tx_q_0 = 16'hC001; tx_i_1 = 16'h7FFE; tx_q_1 = 16'hFFFD;
      d1[0] = model14(tx_i_0); d1[1] = model14(tx_q_0);
      d1[2] = model14(tx_i_1); d1[3] = model14(tx_q_1);
      enable = 1'b0;
      step();
      chk("idle_underrun_kept", 32'(underrun_count), 32'd0);
      enable = 1'b1; base = cyc;
      do_strobe(1'b0, s);
      chk("realign_strobe", 32'(s - base), 32'd8);
      sb_push(s + 6, sid++, d1[0], d1[1], d1[2], d1[3]);
      do_strobe(1'b1, s);
      sb_push(s + 6, sid++, 14'd0, 14'd0, 14'd0, 14'd0);
      chk("mute_entered", 32'(muted), 32'd1);
      chk("underrun_one", 32'(underrun_count), 32'd1);
      s6 = 0;
      for (int k = 0; k < 4; k++) begin
         do_strobe(1'b0, s);
         chk($sformatf("muted_good%0d", k), 32'(log_muted[s]), 32'd1);
         sb_push(s + 6, sid++, 14'd0, 14'd0, 14'd0, 14'd0);
         sb_check();
         s6 = s;
      end
      chk("mute_hold_after_4th", 32'(muted), 32'd1);
      step();
      chk("mute_released", 32'(muted), 32'd0);
      do_strobe(1'b0, s);
      chk("first_real_strobe_gap", 32'(s - s6), 32'd8);
      sb_push(s + 6, sid++, d1[0], d1[1], d1[2], d1[3]);
      repeat (10) step();
      sb_check();

      // Mid-frame reset, then good/good/empty inside MUTE.
      repeat (2) step();
      reset = 1'b1;
      step();
      chk("midrst_data", 32'(dac_data), 32'd0);
      chk("midrst_frame", 32'(dac_frame), 32'd0);
      chk("midrst_underrun", 32'(underrun_count), 32'd0);
      step();
      chk("midrst_data2", 32'(dac_data), 32'd0);
      reset = 1'b0;
      do_strobe(1'b1, s);
      pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      mcount = 0;
      for (int k = 0; k < 8; k++) begin
         do_strobe(pat[k], s);
         if (log_muted[s]) mcount++;
      end
      chk("mute_strobes", 32'(mcount), 32'd7);
      chk("underrun_still_one", 32'(underrun_count), 32'd1);

      // Saturation, enable drop keeps the tally, reset clears it.
      force dut.underrun_r = 16'hFFFF;
      step();
      release dut.underrun_r;
      do_strobe(1'b1, s);
      chk("sat_underrun", 32'(underrun_count), 32'hFFFF);
      chk("sat_muted", 32'(muted), 32'd1);
      enable = 1'b0;
      step();
      chk("dis_txstrobe", 32'(txstrobe), 32'd0);
      chk("dis_data", 32'(dac_data), 32'd0);
      chk("dis_muted", 32'(muted), 32'd0);
      chk("dis_underrun", 32'(underrun_count), 32'hFFFF);
      base = cyc;
      repeat (6) step();
      mcount = 0;
      for (int i = base; i <= cyc; i++)
         if (log_strobe[i] || log_frame[i] || (log_data[i] != 14'd0)) mcount++;
      chk("idle_quiet", 32'(mcount), 32'd0);
      reset = 1'b1;
      step();
      chk("rst_clears_underrun", 32'(underrun_count), 32'd0);
      reset = 1'b0;
      repeat (12) step();
      sb_check();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
